// File: rtl/perceptron_train_ctrl.sv
// -----------------------------------------------------------------------------
// perceptron_train_ctrl
//
// Owns the single-ported perceptron weight SRAM. Frontend lookups and
// backend training read-modify-writes share the port. Training updates are
// filtered (threshold / mispredict / debug), queued in a small FIFO and then
// applied one at a time with saturating +/-1 weight steps. After reset the
// whole table is swept to zero before anything else is allowed.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   debug_mode_i         updates are handshaken but discarded while high
//   lookup_valid_i/index lookup read request; lookup_gnt_o = port owned now,
//                        data on tbl_rdata_i next cycle
//   upd_valid_i/ready_o  training update handshake
//   upd_index_i          entry to train
//   upd_history_i        history used for the prediction
//   upd_taken_i          resolved direction
//   upd_mispredict_i     prediction was wrong
//   upd_outcome_i        signed perceptron sum from prediction time
//   tbl_req_o/we_o       SRAM access / write enable
//   tbl_addr_o/wdata_o   SRAM address / write data
//   tbl_rdata_i          SRAM read data, one cycle after a read request
//   init_done_o          zero sweep finished (sticky until reset)
//   busy_o               FIFO non-empty or a training update in flight
// -----------------------------------------------------------------------------
module perceptron_train_ctrl #(
   parameter int NR_ENTRIES   = 1024,
   parameter int GHR_LENGTH   = 10,
   parameter int WEIGHT_W     = 8,
   parameter int THRESHOLD    = 33,
   parameter int UPD_DEPTH    = 4,
   parameter int STARVE_LIMIT = 8,
   // derived widths; leave at their defaults
   parameter int IDX_W        = $clog2(NR_ENTRIES),
   parameter int EW           = (GHR_LENGTH + 1) * WEIGHT_W,
   parameter int OUT_W        = WEIGHT_W + $clog2(GHR_LENGTH + 2)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    debug_mode_i,
   input  logic                    lookup_valid_i,
   input  logic [IDX_W-1:0]        lookup_index_i,
   output logic                    lookup_gnt_o,
   input  logic                    upd_valid_i,
   output logic                    upd_ready_o,
   input  logic [IDX_W-1:0]        upd_index_i,
   input  logic [GHR_LENGTH-1:0]   upd_history_i,
   input  logic                    upd_taken_i,
   input  logic                    upd_mispredict_i,
   input  logic signed [OUT_W-1:0] upd_outcome_i,
   output logic                    tbl_req_o,
   output logic                    tbl_we_o,
   output logic [IDX_W-1:0]        tbl_addr_o,
   output logic [EW-1:0]           tbl_wdata_o,
   input  logic [EW-1:0]           tbl_rdata_i,
   output logic                    init_done_o,
   output logic                    busy_o
);

   localparam int PTR_W = $clog2(UPD_DEPTH);
   localparam int FE_W  = IDX_W + GHR_LENGTH + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_MOD, S_WR} state_e;

   // One saturating +/-1 step on a signed weight. Overflow shows up as the
   // two top bits of the widened sum disagreeing.
   function automatic logic signed [WEIGHT_W-1:0] sat_step(
      input logic signed [WEIGHT_W-1:0] w,
      input logic                       inc
   );
      logic signed [WEIGHT_W:0]   s;
      logic signed [WEIGHT_W-1:0] r;
      s = {w[WEIGHT_W-1], w};
      s = inc ? (s + (WEIGHT_W+1)'(1)) : (s - (WEIGHT_W+1)'(1));
      if (s[WEIGHT_W] != s[WEIGHT_W-1])
         r = s[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}} : {1'b0, {(WEIGHT_W-1){1'b1}}};
      else
         r = s[WEIGHT_W-1:0];
      return r;
   endfunction

   // w_i' = sat(w_i + t*x_i); t*x_i is +1 exactly when taken equals the
   // input bit (x_0 is the constant-1 bias input).
   function automatic logic [EW-1:0] train_entry(
      input logic [EW-1:0]         entry,
      input logic [GHR_LENGTH-1:0] hist,
      input logic                  taken
   );
      logic [EW-1:0]         res;
      logic [GHR_LENGTH:0]   x;
      x   = {hist, 1'b1};
      res = '0;
      for (int i = 0; i <= GHR_LENGTH; i++)
         res[i*WEIGHT_W +: WEIGHT_W] = sat_step(entry[i*WEIGHT_W +: WEIGHT_W], taken ~^ x[i]);
      return res;
   endfunction

   // Magnitude one bit wider so the most negative sum does not wrap.
   function automatic logic [OUT_W:0] abs_outcome(input logic signed [OUT_W-1:0] v);
      logic signed [OUT_W:0] e;
      e = v;
      return e[OUT_W] ? $unsigned(-e) : $unsigned(e);
   endfunction

   // control state
   state_e             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [STV_W-1:0]   starve_q, starve_d;
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

   // data path (not reset)
   logic [FE_W-1:0]       fifo_mem [UPD_DEPTH];
   logic [IDX_W-1:0]      wk_idx_q;
   logic [GHR_LENGTH-1:0] wk_hist_q;
   logic                  wk_taken_q;
   logic [EW-1:0]         wk_data_q, wk_data_d;

   logic fifo_empty, fifo_full, push, pop, keep;
   logic train_req, train_gnt, force_train;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // Ready ignores a same-cycle pop so a full FIFO never takes a push.
   assign upd_ready_o = done_q && !fifo_full;
   assign keep        = !debug_mode_i &&
                        (upd_mispredict_i || (abs_outcome(upd_outcome_i) <= (OUT_W+1)'(THRESHOLD)));
   assign push        = upd_valid_i && upd_ready_o && keep;
   assign pop         = (state_q == S_IDLE) && !fifo_empty;

   assign train_req    = (state_q == S_RD) || (state_q == S_WR);
   assign force_train  = train_req && (starve_q == STV_W'(STARVE_LIMIT));
   assign lookup_gnt_o = done_q && lookup_valid_i && !force_train;
   assign train_gnt    = train_req && !lookup_gnt_o;

   assign init_done_o = done_q;
   assign busy_o      = !fifo_empty || (state_q != S_IDLE);
   assign wk_data_d   = train_entry(tbl_rdata_i, wk_hist_q, wk_taken_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      done_d      = done_q;
      starve_d    = starve_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      tbl_req_o   = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = '0;
      tbl_wdata_o = '0;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (train_gnt)      starve_d = '0;
      else if (train_req) starve_d = starve_q + 1'b1;

      unique case (state_q)
         S_INIT: begin
            tbl_req_o = 1'b1;
            tbl_we_o  = 1'b1;
            tbl_addr_o = cnt_q;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(NR_ENTRIES - 1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         S_IDLE:  if (pop) state_d = S_RD;
         S_RD:    if (train_gnt) state_d = S_MOD;
         S_MOD:   state_d = S_WR;
         S_WR:    if (train_gnt) state_d = S_IDLE;
         default: state_d = S_INIT;
      endcase

      if (lookup_gnt_o) begin
         tbl_req_o  = 1'b1;
         tbl_we_o   = 1'b0;
         tbl_addr_o = lookup_index_i;
      end else if (train_gnt) begin
         tbl_req_o  = 1'b1;
         tbl_we_o   = (state_q == S_WR);
         tbl_addr_o = wk_idx_q;
         if (state_q == S_WR) tbl_wdata_o = wk_data_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_INIT;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         starve_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         starve_q <= starve_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {upd_index_i, upd_history_i, upd_taken_i};
      if (pop)
         {wk_idx_q, wk_hist_q, wk_taken_q} <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
      // modify step: data for the granted table read is on the bus now
      if (state_q == S_MOD)
         wk_data_q <= wk_data_d;
   end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
module tb_perceptron_train_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               debug_mode = 1'b0;
   logic               lookup_valid = 1'b0;
   logic [9:0]         lookup_index = '0;
   logic               lookup_gnt;
   logic               upd_valid = 1'b0;
   logic               upd_ready;
   logic [9:0]         upd_index = '0;
   logic [9:0]         upd_history = '0;
   logic               upd_taken = 1'b0;
   logic               upd_mispredict = 1'b0;
   logic signed [11:0] upd_outcome = '0;
   logic               tbl_req, tbl_we;
   logic [9:0]         tbl_addr;
   logic [87:0]        tbl_wdata;
   logic [87:0]        tbl_rdata = '0;
   logic               init_done, busy;

   perceptron_train_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug_mode),
      .lookup_valid_i(lookup_valid), .lookup_index_i(lookup_index), .lookup_gnt_o(lookup_gnt),
      .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_index_i(upd_index),
      .upd_history_i(upd_history), .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
      .upd_outcome_i(upd_outcome), .tbl_req_o(tbl_req), .tbl_we_o(tbl_we), .tbl_addr_o(tbl_addr),
      .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata), .init_done_o(init_done), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // SRAM model with a bench-side backdoor write port for preloading
   logic [87:0] mem [1024];
   logic        bd_we = 1'b0;
   logic [9:0]  bd_addr = '0;
   logic [87:0] bd_data = '0;
   int          cyc = 0;
   logic [9:0]  wr_addr_q [$];
   logic [87:0] wr_data_q [$];
   int          wr_cyc_q  [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (tbl_req && tbl_we) mem[tbl_addr] <= tbl_wdata;
      if (tbl_req && !tbl_we) tbl_rdata <= mem[tbl_addr];
      if (tbl_req && tbl_we && init_done) begin
         wr_addr_q.push_back(tbl_addr);
         wr_data_q.push_back(tbl_wdata);
         wr_cyc_q.push_back(cyc);
      end
   end

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Offers one update starting at a drive point; returns at the drive point
   // of the cycle after the handshake.
   task automatic do_update(input logic [9:0] idx, input logic [9:0] hist, input logic tk,
                            input logic mis, input logic signed [11:0] outc, input logic dbg,
                            output logic ok, output int hs);
      upd_index = idx; upd_history = hist; upd_taken = tk;
      upd_mispredict = mis; upd_outcome = outc; debug_mode = dbg; upd_valid = 1'b1;
      ok = 1'b0; hs = 0;
      for (int t = 0; t < 50; t++) begin
         #1;
         if (upd_ready) begin ok = 1'b1; hs = cyc; break; end
         @(negedge clk); #1;
      end
      if (ok) begin @(negedge clk); #1; end
      upd_valid = 1'b0; debug_mode = 1'b0;
   endtask

   // Starts right after reset release at a negedge.
   task automatic sweep_check(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         #1;
         if (!(tbl_req && tbl_we && tbl_addr == 10'(i) && tbl_wdata == 88'h0 &&
               !lookup_gnt && !upd_ready && !init_done)) bad++;
         @(negedge clk);
      end
      #1;
      check({name, "_bad_cycles"}, bad, 0);
      check({name, "_init_done"}, init_done, 1'b1);
      check({name, "_busy_idle"}, busy, 1'b0);
   endtask

   typedef struct {
      logic [9:0]         idx;
      logic [9:0]         hist;
      logic               taken;
      logic               mis;
      logic signed [11:0] outc;
      logic               dbg;
      logic               pre;
      logic [87:0]        pre_data;
      logic               exp_wr;
      logic [87:0]        exp_data;
   } vec_t;

   vec_t        vec [8];
   logic        ok;
   int          hs, n0;
   logic [87:0] exp_bp [5];
   logic [9:0]  exp_bp_addr [5];

   initial begin
      vec[0] = '{10'd5,  10'b0000000001, 1'b1, 1'b1, 12'sd0,   1'b0, 1'b0, 88'h0,
                 1'b1, {{9{8'hFF}}, 8'h01, 8'h01}};
      vec[1] = '{10'd7,  10'h3FF,        1'b1, 1'b1, 12'sd0,   1'b0, 1'b1, {11{8'h7F}},
                 1'b1, {11{8'h7F}}};
      vec[2] = '{10'd9,  10'b0,          1'b1, 1'b0, 12'sd40,  1'b0, 1'b0, 88'h0,
                 1'b0, 88'h0};
      vec[3] = '{10'd9,  10'b1010101010, 1'b0, 1'b0, 12'sd33,  1'b0, 1'b0, 88'h0,
                 1'b1, 88'hFF01FF01FF01FF01FF01FF};
      vec[4] = '{10'd11, 10'b0,          1'b1, 1'b1, 12'sd0,   1'b1, 1'b0, 88'h0,
                 1'b0, 88'h0};
      vec[5] = '{10'd12, 10'b0,          1'b0, 1'b0, -12'sd33, 1'b0, 1'b1, {11{8'h80}},
                 1'b1, {{10{8'h81}}, 8'h80}};
      vec[6] = '{10'd13, 10'b0,          1'b1, 1'b0, -12'sd34, 1'b0, 1'b0, 88'h0,
                 1'b0, 88'h0};
      vec[7] = '{10'd5,  10'b0000000001, 1'b1, 1'b1, 12'sd100, 1'b0, 1'b0, 88'h0,
                 1'b1, {{9{8'hFE}}, 8'h02, 8'h02}};

      exp_bp_addr[0] = 10'd30; exp_bp[0] = {{10{8'hFF}}, 8'h01};
      exp_bp_addr[1] = 10'd31; exp_bp[1] = {{10{8'hFF}}, 8'h01};
      exp_bp_addr[2] = 10'd30; exp_bp[2] = {{10{8'hFE}}, 8'h02};
      exp_bp_addr[3] = 10'd32; exp_bp[3] = {11{8'hFF}};
      exp_bp_addr[4] = 10'd33; exp_bp[4] = {{10{8'h01}}, 8'hFF};

      // ---- reset values (lookups requested throughout init) ----
      lookup_valid = 1'b1;
      #3;
      check("rst_lookup_gnt", lookup_gnt, 1'b0);
      check("rst_upd_ready",  upd_ready,  1'b0);
      check("rst_init_done",  init_done,  1'b0);
      check("rst_busy",       busy,       1'b1);
      check("rst_tbl",        {tbl_req, tbl_we, tbl_addr, tbl_wdata}, {1'b1, 1'b1, 10'd0, 88'h0});
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      sweep_check("init1");
      check("init1_lookup_gnt", lookup_gnt, 1'b1);
      check("init1_upd_ready",  upd_ready,  1'b1);
      lookup_valid = 1'b0;
      @(negedge clk); #1;

      // ---- table-driven uncontended updates ----
      for (int v = 0; v < 8; v++) begin
         if (vec[v].pre) begin
            bd_we = 1'b1; bd_addr = vec[v].idx; bd_data = vec[v].pre_data;
            @(negedge clk); #1;
            bd_we = 1'b0;
         end
         n0 = wr_addr_q.size();
         do_update(vec[v].idx, vec[v].hist, vec[v].taken, vec[v].mis, vec[v].outc, vec[v].dbg, ok, hs);
         check($sformatf("v%0d_handshake", v), ok, 1'b1);
         if (vec[v].exp_wr) begin
            for (int t = 0; t < 20 && wr_addr_q.size() == n0; t++) begin @(negedge clk); #1; end
            check($sformatf("v%0d_nwrites", v), wr_addr_q.size(), n0 + 1);
            if (wr_addr_q.size() > n0) begin
               check($sformatf("v%0d_addr", v),    wr_addr_q[n0], vec[v].idx);
               check($sformatf("v%0d_data", v),    wr_data_q[n0], vec[v].exp_data);
               check($sformatf("v%0d_latency", v), wr_cyc_q[n0] - hs, 4);
            end
         end else begin
            for (int t = 0; t < 8; t++) begin @(negedge clk); #1; end
            check($sformatf("v%0d_nwrites", v), wr_addr_q.size(), n0);
         end
         @(negedge clk); #1;
         check($sformatf("v%0d_busy", v), busy, 1'b0);
      end

      // ---- starvation: continuous lookups, one pending update ----
      lookup_valid = 1'b1; lookup_index = 10'd3;
      do_update(10'd20, 10'b0, 1'b1, 1'b1, 12'sd0, 1'b0, ok, hs);
      check("stv_handshake", ok, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         #1;
         check($sformatf("stv_gnt_k%0d", k), lookup_gnt, (k != 10 && k != 20));
         if (k == 10) check("stv_rd", {tbl_req, tbl_we, tbl_addr}, {1'b1, 1'b0, 10'd20});
         if (k == 20) check("stv_wr", {tbl_req, tbl_we, tbl_addr, tbl_wdata},
                            {1'b1, 1'b1, 10'd20, {{10{8'hFF}}, 8'h01}});
         @(negedge clk); #1;
      end
      for (int t = 0; t < 3; t++) begin @(negedge clk); #1; end
      check("stv_busy", busy, 1'b0);

      // ---- backpressure: 5 back-to-back updates under contention ----
      n0 = wr_addr_q.size();
      do_update(10'd30, 10'b0,   1'b1, 1'b1, 12'sd0, 1'b0, ok, hs); check("bp_hs0", ok, 1'b1);
      do_update(10'd31, 10'b0,   1'b1, 1'b1, 12'sd0, 1'b0, ok, hs); check("bp_hs1", ok, 1'b1);
      do_update(10'd30, 10'b0,   1'b1, 1'b1, 12'sd0, 1'b0, ok, hs); check("bp_hs2", ok, 1'b1);
      do_update(10'd32, 10'h3FF, 1'b0, 1'b1, 12'sd0, 1'b0, ok, hs); check("bp_hs3", ok, 1'b1);
      do_update(10'd33, 10'b0,   1'b0, 1'b1, 12'sd0, 1'b0, ok, hs); check("bp_hs4", ok, 1'b1);
      #1;
      check("bp_ready_full", upd_ready, 1'b0);
      for (int t = 0; t < 400 && wr_addr_q.size() < n0 + 5; t++) begin @(negedge clk); #1; end
      check("bp_nwrites", wr_addr_q.size(), n0 + 5);
      if (wr_addr_q.size() >= n0 + 5) begin
         for (int j = 0; j < 5; j++) begin
            check($sformatf("bp_addr%0d", j), wr_addr_q[n0+j], exp_bp_addr[j]);
            check($sformatf("bp_data%0d", j), wr_data_q[n0+j], exp_bp[j]);
         end
      end
      lookup_valid = 1'b0;
      @(negedge clk); #1;

      // ---- asynchronous reset in the middle of an RMW ----
      n0 = wr_addr_q.size();
      do_update(10'd40, 10'b0, 1'b1, 1'b1, 12'sd0, 1'b0, ok, hs);
      check("rmw_handshake", ok, 1'b1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rmw_rst_tbl", {tbl_req, tbl_we, tbl_addr, tbl_wdata}, {1'b1, 1'b1, 10'd0, 88'h0});
      check("rmw_rst_flags", {init_done, upd_ready, lookup_gnt, busy}, 4'b0001);
      @(negedge clk);
      rst_n = 1'b1;
      sweep_check("init2");
      for (int t = 0; t < 10; t++) begin @(negedge clk); #1; end
      check("rmw_lost", wr_addr_q.size(), n0);
      check("rmw_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
